// File: rtl/reg_file_sb_if.sv
// Bus between decode/writeback and the scoreboarded register file.
// Carries the read, write and issue channels plus the busy status.
interface reg_file_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] ard1;
  logic [AW-1:0] ard2;
  logic [DW-1:0] dout1;
  logic [DW-1:0] dout2;
  logic [AW-1:0] awr;
  logic [DW-1:0] din;
  logic          wren;
  logic          issen;
  logic [AW-1:0] issadr;
  logic          busy1;
  logic          busy2;
  logic [AW:0]   busycnt;

  modport master (
    output ard1, ard2, awr, din, wren, issen, issadr,
    input  dout1, dout2, busy1, busy2, busycnt
  );

  modport slave (
    input  ard1, ard2, awr, din, wren, issen, issadr,
    output dout1, dout2, busy1, busy2, busycnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// MIPS general-purpose register file: two combinational read ports, one write
// port, optional r0 hardwiring and write bypass, and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [AW:0]      cnt;

  logic wr_ok, iss_ok, inc, dec;
  logic hit1, hit2;

  // r0 is neither written nor tracked when it is hardwired.
  assign wr_ok  = bus.wren  && !(ZERO_REG != 0 && bus.awr    == '0);
  assign iss_ok = bus.issen && !(ZERO_REG != 0 && bus.issadr == '0);

  // Count moves only when a bit actually changes state.
  assign inc = iss_ok && !busy[bus.issadr];
  assign dec = wr_ok && busy[bus.awr] && !(iss_ok && bus.issadr == bus.awr);

  // NOTE: the array is reset element by element because reads must return 0
  // right after reset; that forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.awr] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments take effect in order, so the issue
      // (set) below overrides a writeback (clear) to the same register.
      if (wr_ok)  busy[bus.awr]    <= 1'b0;
      if (iss_ok) busy[bus.issadr] <= 1'b1;
      case ({inc, dec})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Bypass hits exclude a hardwired r0 and are suppressed while in reset.
  assign hit1 = (BYPASS != 0) && rst_n && wr_ok && (bus.awr == bus.ard1);
  assign hit2 = (BYPASS != 0) && rst_n && wr_ok && (bus.awr == bus.ard2);

  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    bus.dout1 = mem[bus.ard1];
    bus.busy1 = busy[bus.ard1];
    if (!rst_n || (ZERO_REG != 0 && bus.ard1 == '0)) begin
      bus.dout1 = '0;
      bus.busy1 = 1'b0;
    end else if (hit1) begin
      bus.dout1 = bus.din;
      bus.busy1 = 1'b0;
    end
  end

  always_comb begin
    bus.dout2 = mem[bus.ard2];
    bus.busy2 = busy[bus.ard2];
    if (!rst_n || (ZERO_REG != 0 && bus.ard2 == '0)) begin
      bus.dout2 = '0;
      bus.busy2 = 1'b0;
    end else if (hit2) begin
      bus.dout2 = bus.din;
      bus.busy2 = 1'b0;
    end
  end

  assign bus.busycnt = cnt;
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: table-driven vectors through a scoreboard
// queue, plus hand sequences for reset, no-bypass, saturation and async reset.
module tb_reg_file_sb;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  reg_file_sb_if #(.DW(32), .AW(5)) ifc ();
  reg_file_sb_if #(.DW(32), .AW(5)) ifc_nb ();

  reg_file_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );
  reg_file_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(ifc_nb)
  );

  // The no-bypass copy sees exactly the same stimulus.
  assign ifc_nb.ard1   = ifc.ard1;
  assign ifc_nb.ard2   = ifc.ard2;
  assign ifc_nb.awr    = ifc.awr;
  assign ifc_nb.din    = ifc.din;
  assign ifc_nb.wren   = ifc.wren;
  assign ifc_nb.issen  = ifc.issen;
  assign ifc_nb.issadr = ifc.issadr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wren;
    logic [4:0]  awr;
    logic [31:0] din;
    logic        issen;
    logic [4:0]  issadr;
    logic [4:0]  ard1;
    logic [4:0]  ard2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl [13];
  vec_t sb_q [$];

  function automatic vec_t mk(input logic we, input logic [4:0] aw, input logic [31:0] dn,
                              input logic ie, input logic [4:0] ia,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic eb1, input logic eb2, input logic [5:0] ec);
    vec_t v;
    v.wren = we; v.awr = aw; v.din = dn; v.issen = ie; v.issadr = ia;
    v.ard1 = a1; v.ard2 = a2; v.d1 = e1; v.d2 = e2; v.b1 = eb1; v.b2 = eb2; v.cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    ifc.wren = 1'b0; ifc.awr = '0; ifc.din = '0;
    ifc.issen = 1'b0; ifc.issadr = '0;
  endtask

  task automatic drive(input vec_t v);
    ifc.wren = v.wren; ifc.awr = v.awr; ifc.din = v.din;
    ifc.issen = v.issen; ifc.issadr = v.issadr;
    ifc.ard1 = v.ard1; ifc.ard2 = v.ard2;
    sb_q.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    checks = 0;
    errors = 0;

    //              we aw  din           ie ia  a1  a2  exp d1        exp d2        b1 b2 cnt
    tbl[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 0);
    tbl[1]  = mk(1, 0,  32'h12345678, 0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 0);
    tbl[2]  = mk(1, 7,  32'hA5A5A5A5, 0, 0,  7,  5,  32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 0);
    tbl[3]  = mk(0, 0,  32'h0,        1, 3,  3,  7,  32'h0,        32'hA5A5A5A5, 0, 0, 1);
    tbl[4]  = mk(1, 3,  32'h11111111, 1, 3,  3,  0,  32'h11111111, 32'h0,        0, 0, 1);
    tbl[5]  = mk(0, 0,  32'h0,        0, 0,  3,  3,  32'h11111111, 32'h11111111, 1, 1, 1);
    tbl[6]  = mk(1, 3,  32'h22222222, 0, 0,  3,  7,  32'h22222222, 32'hA5A5A5A5, 0, 0, 0);
    tbl[7]  = mk(0, 0,  32'h0,        1, 0,  0,  3,  32'h0,        32'h22222222, 0, 0, 0);
    tbl[8]  = mk(1, 12, 32'hCAFEF00D, 1, 10, 12, 10, 32'hCAFEF00D, 32'h0,        0, 0, 1);
    tbl[9]  = mk(1, 10, 32'h0BADF00D, 1, 11, 10, 11, 32'h0BADF00D, 32'h0,        0, 0, 1);
    tbl[10] = mk(0, 0,  32'h0,        1, 11, 11, 10, 32'h0,        32'h0BADF00D, 1, 0, 1);
    tbl[11] = mk(1, 11, 32'h00000005, 0, 0,  10, 11, 32'h0BADF00D, 32'h00000005, 0, 0, 0);
    tbl[12] = mk(0, 0,  32'h0,        0, 0,  11, 12, 32'h00000005, 32'hCAFEF00D, 0, 0, 0);

    // Reset, with a write/issue/bypass attempt that must be ignored.
    rst_n = 1'b0;
    ifc.wren = 1'b1; ifc.awr = 5'd5; ifc.din = 32'hFFFF_FFFF;
    ifc.issen = 1'b1; ifc.issadr = 5'd5;
    ifc.ard1 = 5'd5; ifc.ard2 = 5'd6;
    #3;
    check("rst_bypass_dout1", 64'(ifc.dout1), 64'h0);
    check("rst_bypass_busy1", 64'(ifc.busy1), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    check("rst_busycnt", 64'(ifc.busycnt), 64'h0);

    for (int a = 0; a < 32; a++) begin
      ifc.ard1 = 5'(a);
      ifc.ard2 = 5'(31 - a);
      #1;
      check($sformatf("rst_dout1[%0d]", a), 64'(ifc.dout1), 64'h0);
      check($sformatf("rst_dout2[%0d]", 31 - a), 64'(ifc.dout2), 64'h0);
      check($sformatf("rst_busy[%0d]", a), 64'({ifc.busy1, ifc.busy2}), 64'h0);
    end

    // Table vectors through the scoreboard queue.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      e = sb_q.pop_front();
      check($sformatf("v%0d_dout1", i), 64'(ifc.dout1), 64'(e.d1));
      check($sformatf("v%0d_dout2", i), 64'(ifc.dout2), 64'(e.d2));
      check($sformatf("v%0d_busy1", i), 64'(ifc.busy1), 64'(e.b1));
      check($sformatf("v%0d_busy2", i), 64'(ifc.busy2), 64'(e.b2));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_busycnt", i), 64'(ifc.busycnt), 64'(e.cnt));
    end

    // Without bypass the old value is visible until after the edge.
    @(negedge clk);
    ifc.wren = 1'b1; ifc.awr = 5'd7; ifc.din = 32'h5A5A5A5A;
    ifc.ard1 = 5'd7; ifc.ard2 = 5'd7;
    #2;
    check("byp_dout1", 64'(ifc.dout1), 64'h5A5A5A5A);
    check("nobyp_dout1_before", 64'(ifc_nb.dout1), 64'hA5A5A5A5);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("nobyp_dout1_after", 64'(ifc_nb.dout1), 64'h5A5A5A5A);

    // Issue every address; r0 is skipped, so the count tops out at 31.
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      ifc.issen = 1'b1; ifc.issadr = 5'(a);
    end
    @(negedge clk);
    idle();
    ifc.ard1 = 5'd4; ifc.ard2 = 5'd0;
    #2;
    check("sat_busycnt", 64'(ifc.busycnt), 64'd31);
    check("sat_busy1_r4", 64'(ifc.busy1), 64'h1);
    check("sat_busy2_r0", 64'(ifc.busy2), 64'h0);
    ifc.issen = 1'b1; ifc.issadr = 5'd4;
    @(posedge clk);
    #1;
    idle();
    check("sat_reissue_busycnt", 64'(ifc.busycnt), 64'd31);

    // Clear everything, then write r9 and mark it busy in one cycle.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      ifc.wren = 1'b1; ifc.awr = 5'(a); ifc.din = '0;
    end
    @(negedge clk);
    idle();
    #1;
    check("drain_busycnt", 64'(ifc.busycnt), 64'd0);
    ifc.wren = 1'b1; ifc.awr = 5'd9; ifc.din = 32'h0000FFFF;
    ifc.issen = 1'b1; ifc.issadr = 5'd9;
    @(negedge clk);
    idle();
    ifc.ard1 = 5'd9;
    #2;
    check("pre_rst_dout1", 64'(ifc.dout1), 64'h0000FFFF);
    check("pre_rst_busy1", 64'(ifc.busy1), 64'h1);
    check("pre_rst_busycnt", 64'(ifc.busycnt), 64'd1);

    // Asynchronous reset between edges takes effect immediately.
    rst_n = 1'b0;
    #1;
    check("arst_dout1", 64'(ifc.dout1), 64'h0);
    check("arst_busy1", 64'(ifc.busy1), 64'h0);
    check("arst_busycnt", 64'(ifc.busycnt), 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_dout1", 64'(ifc.dout1), 64'h0);
    check("post_rst_busycnt", 64'(ifc.busycnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
